// File: rtl/dut_clock_sequencer.sv
// Command-driven DUT clock/reset sequencer: divided clk_dut, rst_dut,
// free-run, N-edge burst and clocked-reset sequences.
// Ports: CLK/rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_arg
// command handshake; clk_dut, rst_dut, busy, cmd_err, edge_count outputs.
module dut_clock_sequencer #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 6000,
  parameter int RST_CYCLES  = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DIV_W-1:0] cmd_arg,
  output logic             clk_dut,
  output logic             rst_dut,
  output logic             busy,
  output logic             cmd_err,
  output logic [DIV_W-1:0] edge_count
);

  localparam logic [1:0] OP_SET_DIV = 2'd0;
  localparam logic [1:0] OP_RESET   = 2'd1;
  localparam logic [1:0] OP_RUN     = 2'd2;
  localparam logic [1:0] OP_STOP    = 2'd3;

  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] SAT  = '1;
  localparam logic [DIV_W-1:0] DDIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] RCYC = DIV_W'(RST_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_BURST,
    S_RUN,
    S_STOP
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [DIV_W-1:0] divcnt, divcnt_n;
  logic [DIV_W-1:0] rem, rem_n;
  logic [DIV_W-1:0] ec_n;
  logic             clk_n;
  logic             rst_dut_n;
  logic             err_n;
  logic             run_div;
  logic             tick;
  logic             accept;

  assign tick   = (divcnt == div);
  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= S_RESET;
      div        <= DDIV;
      divcnt     <= '0;
      rem        <= RCYC;
      clk_dut    <= 1'b0;
      rst_dut    <= 1'b1;
      edge_count <= '0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_n;
      div        <= div_n;
      divcnt     <= divcnt_n;
      rem        <= rem_n;
      clk_dut    <= clk_n;
      rst_dut    <= rst_dut_n;
      edge_count <= ec_n;
      cmd_err    <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    div_n     = div;
    divcnt_n  = divcnt;
    rem_n     = rem;
    clk_n     = clk_dut;
    rst_dut_n = rst_dut;
    ec_n      = edge_count;
    err_n     = 1'b0;
    run_div   = 1'b0;

    unique case (state)
      S_IDLE: begin
        divcnt_n = '0;
        clk_n    = 1'b0;
        if (accept) begin
          unique case (cmd_op)
            OP_SET_DIV: div_n = cmd_arg;
            OP_RESET: begin
              rst_dut_n = 1'b1;
              rem_n     = (cmd_arg == '0) ? ONE : cmd_arg;
              ec_n      = '0;
              state_n   = S_RESET;
            end
            OP_RUN: begin
              ec_n = '0;
              if (cmd_arg == '0) begin
                state_n = S_RUN;
              end else begin
                rem_n   = cmd_arg;
                state_n = S_BURST;
              end
            end
            OP_STOP: ;
            default: ;
          endcase
        end
      end
      S_RESET, S_BURST, S_RUN: run_div = 1'b1;
      S_STOP: begin
        // A low phase may be cut short; a high phase never is.
        if (clk_dut) begin
          run_div = 1'b1;
        end else begin
          divcnt_n = '0;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (run_div) begin
      if (tick) begin
        divcnt_n = '0;
        clk_n    = ~clk_dut;
        if (!clk_dut) begin
          if (state != S_RUN) rem_n = rem - ONE;
          if (edge_count != SAT) ec_n = edge_count + ONE;
        end else if (state == S_STOP ||
                     (state != S_RUN && rem == '0)) begin
          state_n = S_IDLE;
          if (state == S_RESET) rst_dut_n = 1'b0;
        end
      end else begin
        divcnt_n = divcnt + ONE;
      end
    end

    // Free-run only honours STOP; anything else is swallowed.
    if (state == S_RUN && accept) begin
      if (cmd_op == OP_STOP) state_n = S_STOP;
      else err_n = 1'b1;
    end
  end

  always_comb begin
    cmd_ready = (state == S_IDLE) || (state == S_RUN);
    busy      = (state != S_IDLE);
  end

endmodule
